// File: rtl/svm_matmul2.sv
// svm_matmul2: second matmul stage of the systolic SVM classifier.
// Streams one kernel value per support vector, multiplies it by the valence
// and arousal dual coefficients from the ROM, and accumulates both dot
// products in parallel lanes. At the end of a sample the valence sum and then
// the arousal sum are emitted on one shared result bus, one cycle apart.

// One multiply-accumulate lane (valence or arousal).
module svm_matmul2_mac #(
    parameter int K_W   = 24,
    parameter int NBITS = 16,
    parameter int ACC_W = 47
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [K_W-1:0]   k,
    input  logic signed [NBITS-1:0] alpha,
    output logic signed [ACC_W-1:0] acc
);
    // Full-precision signed product; the accumulator carries enough growth
    // bits for SUP_WIDTH terms, so no saturation is needed.
    logic signed [NBITS+K_W-1:0] prod;

    assign prod = k * alpha;

    // Add one product per stage-1 cycle; clear once the sample is emitted.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end
endmodule

module svm_matmul2 #(
    parameter int NBITS         = 16,
    parameter int F_WIDTH       = 214,
    parameter int LOG_F_WIDTH   = 8,
    parameter int SUP_WIDTH     = 100,
    parameter int LOG_SUP_WIDTH = 7
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [NBITS+LOG_F_WIDTH-1:0]           kernel_data,
    input  logic                                          kernel_valid,
    output logic                                          kernel_ready,
    output logic [LOG_SUP_WIDTH-1:0]                      alpha_addr,
    input  logic signed [NBITS-1:0]                       v_alpha,
    input  logic signed [NBITS-1:0]                       a_alpha,
    output logic [NBITS*(NBITS+LOG_F_WIDTH)+LOG_SUP_WIDTH-1:0] matmul2_result,
    output logic                                          matmul2_v_valid,
    output logic                                          matmul2_a_valid
);
    localparam int K_W       = NBITS + LOG_F_WIDTH;
    localparam int ACC_W     = NBITS + K_W + LOG_SUP_WIDTH;
    localparam int RES_W     = NBITS * (NBITS + LOG_F_WIDTH) + LOG_SUP_WIDTH;
    localparam int NUM_LANES = 2;   // lane 0 = valence, lane 1 = arousal

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] OUT_V = 2'd2;
    localparam logic [1:0] OUT_A = 2'd3;

    // Growth bits must cover the feature count and the support-vector count.
    if ((1 << LOG_F_WIDTH) < F_WIDTH || (1 << LOG_SUP_WIDTH) < SUP_WIDTH) begin : g_cfg_err
        $error("svm_matmul2: LOG_F_WIDTH/LOG_SUP_WIDTH too small");
    end

    logic [1:0]                           state;
    logic [LOG_SUP_WIDTH-1:0]             idx;
    logic                                 fire;
    logic                                 last;
    logic                                 s1_vld;
    logic                                 acc_clr;
    logic signed [K_W-1:0]                k_reg;
    logic [NUM_LANES-1:0][NBITS-1:0]      alpha;
    logic [NUM_LANES-1:0][ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]              v_acc;
    logic signed [ACC_W-1:0]              a_acc;

    assign kernel_ready = (state == ACCUM);
    assign fire         = kernel_valid && kernel_ready;
    assign last         = (idx == LOG_SUP_WIDTH'(SUP_WIDTH - 1));
    assign alpha_addr   = idx;
    assign acc_clr      = (state == OUT_A);
    assign alpha        = {a_alpha, v_alpha};
    assign v_acc        = $signed(acc[0]);
    assign a_acc        = $signed(acc[1]);

    // Sequencing: count fired kernels, then flush, emit valence, emit arousal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (fire) begin
                        if (last) begin
                            idx   <= '0;
                            state <= FLUSH;
                        end else begin
                            idx <= idx + LOG_SUP_WIDTH'(1);
                        end
                    end
                end
                FLUSH:   state <= OUT_V;
                OUT_V:   state <= OUT_A;
                default: state <= ACCUM;
            endcase
        end
    end

    // Stage 1 operand capture: the ROM word arrives one cycle after the fire,
    // aligned with k_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            k_reg  <= '0;
        end else begin
            s1_vld <= fire;
            if (fire)
                k_reg <= kernel_data;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        svm_matmul2_mac #(
            .K_W   (K_W),
            .NBITS (NBITS),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk   (clk),
            .rst   (rst),
            .clr   (acc_clr),
            .en    (s1_vld),
            .k     (k_reg),
            .alpha ($signed(alpha[g])),
            .acc   (acc[g])
        );
    end

    // Result bus: valence then arousal, each a one-cycle pulse, sign-extended.
    always_ff @(posedge clk) begin
        if (rst) begin
            matmul2_result  <= '0;
            matmul2_v_valid <= 1'b0;
            matmul2_a_valid <= 1'b0;
        end else begin
            matmul2_v_valid <= 1'b0;
            matmul2_a_valid <= 1'b0;
            if (state == OUT_V) begin
                matmul2_result  <= RES_W'(v_acc);
                matmul2_v_valid <= 1'b1;
            end else if (state == OUT_A) begin
                matmul2_result  <= RES_W'(a_acc);
                matmul2_a_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_svm_matmul2.sv
// tb_svm_matmul2: directed and randomized checks of svm_matmul2 against a
// per-sample dot-product model with the documented handshake timing.
module tb_svm_matmul2;
    localparam int NB  = 4;
    localparam int FW  = 4;
    localparam int LFW = 2;
    localparam int SW  = 3;
    localparam int LSW = 2;
    localparam int KW  = NB + LFW;
    localparam int RW  = NB * (NB + LFW) + LSW;

    logic            clk = 1'b0;
    logic            rst;
    logic [KW-1:0]   kernel_data;
    logic            kernel_valid;
    logic            kernel_ready;
    logic [LSW-1:0]  alpha_addr;
    logic [NB-1:0]   v_alpha;
    logic [NB-1:0]   a_alpha;
    logic [RW-1:0]   matmul2_result;
    logic            matmul2_v_valid;
    logic            matmul2_a_valid;

    svm_matmul2 #(
        .NBITS(NB), .F_WIDTH(FW), .LOG_F_WIDTH(LFW),
        .SUP_WIDTH(SW), .LOG_SUP_WIDTH(LSW)
    ) dut (
        .clk(clk), .rst(rst),
        .kernel_data(kernel_data), .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
        .alpha_addr(alpha_addr), .v_alpha(v_alpha), .a_alpha(a_alpha),
        .matmul2_result(matmul2_result),
        .matmul2_v_valid(matmul2_v_valid), .matmul2_a_valid(matmul2_a_valid)
    );

    always #5 clk = ~clk;

    // Coefficient ROM with one cycle of read latency.
    logic signed [NB-1:0] vrom [4];
    logic signed [NB-1:0] arom [4];
    always @(posedge clk) begin
        v_alpha <= vrom[alpha_addr];
        a_alpha <= arom[alpha_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state: kernels taken in this sample, running sums, pending pulses.
    int cyc = 0;
    int cnt = 0;
    int sv = 0;
    int sa = 0;
    int lock_until = 0;
    int ev_cyc = -1;
    int ea_cyc = -1;
    logic [RW-1:0] ev_val = '0;
    logic [RW-1:0] ea_val = '0;
    logic [RW-1:0] last_v = '0;
    logic [RW-1:0] last_a = '0;
    int last_v_cyc = 0;
    int n_vp = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task automatic set_rom(input int v0, input int v1, input int v2,
                           input int a0, input int a1, input int a2);
        vrom[0] = NB'(v0); vrom[1] = NB'(v1); vrom[2] = NB'(v2); vrom[3] = '0;
        arom[0] = NB'(a0); arom[1] = NB'(a1); arom[2] = NB'(a2); arom[3] = '0;
    endtask

    // One clock: drive at the falling edge, check, advance the model, check outputs.
    task automatic step(input logic kv, input logic [KW-1:0] kd, input logic r,
                        output logic fired);
        logic exp_rdy;
        kernel_valid = kv;
        kernel_data  = kd;
        rst          = r;
        #1;
        exp_rdy = (cyc >= lock_until);
        chk("kernel_ready", 64'(kernel_ready), 64'(exp_rdy));
        if (exp_rdy && !r)
            chk("alpha_addr", 64'(alpha_addr), 64'(cnt));
        fired = kv && exp_rdy && !r;
        @(posedge clk);
        cyc++;
        if (r) begin
            cnt = 0; sv = 0; sa = 0; lock_until = 0; ev_cyc = -1; ea_cyc = -1;
        end else if (fired) begin
            sv += int'($signed(kd)) * int'(vrom[cnt]);
            sa += int'($signed(kd)) * int'(arom[cnt]);
            cnt++;
            if (cnt == SW) begin
                ev_cyc = cyc + 2; ea_cyc = cyc + 3;
                ev_val = RW'(sv); ea_val = RW'(sa);
                lock_until = cyc + 3;
                cnt = 0; sv = 0; sa = 0;
            end
        end
        @(negedge clk);
        chk("v_valid", 64'(matmul2_v_valid), 64'(ev_cyc == cyc));
        chk("a_valid", 64'(matmul2_a_valid), 64'(ea_cyc == cyc));
        if (matmul2_v_valid) begin
            n_vp++;
            last_v = matmul2_result;
            last_v_cyc = cyc;
        end
        if (matmul2_a_valid)
            last_a = matmul2_result;
        if (ev_cyc == cyc) chk("v_result", 64'(matmul2_result), 64'(ev_val));
        if (ea_cyc == cyc) chk("a_result", 64'(matmul2_result), 64'(ea_val));
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++) step(1'b0, KW'($urandom), 1'b0, f);
    endtask

    // Present one kernel until accepted; garbage-free hold of data while stalled.
    task automatic send(input logic [KW-1:0] kd);
        logic f;
        int g = 0;
        do begin
            step(1'b1, kd, 1'b0, f);
            g++;
        end while (!f && g < 8);
        if (!f) chk("send_timeout", 64'(g), 64'(0));
    endtask

    initial begin
        int t0, dva, dvb, nv0;
        logic f;
        rst = 1'b1;
        kernel_valid = 1'b0;
        kernel_data = '0;
        set_rom(1, 1, 1, -1, 2, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_result", 64'(matmul2_result), 64'(0));
        chk("rst_v_valid", 64'(matmul2_v_valid), 64'(0));
        chk("rst_a_valid", 64'(matmul2_a_valid), 64'(0));
        chk("rst_ready", 64'(kernel_ready), 64'(1));
        chk("rst_addr", 64'(alpha_addr), 64'(0));

        // Basic sample, back-to-back kernels.
        t0 = cyc;
        send(1); send(2); send(3);
        idle(6);
        dva = last_v_cyc - t0;
        chk("basic_v", 64'(last_v), 64'(RW'(6)));
        chk("basic_a", 64'(last_a), 64'(RW'(3)));

        // Same sample with a two-cycle gap after the first kernel.
        t0 = cyc;
        send(1);
        idle(2);
        send(2); send(3);
        idle(6);
        dvb = last_v_cyc - t0;
        chk("gap_v", 64'(last_v), 64'(RW'(6)));
        chk("gap_a", 64'(last_a), 64'(RW'(3)));
        chk("gap_shift", 64'(dvb - dva), 64'(2));

        // Extremes: full sign extension on the result bus.
        set_rom(-8, -8, -8, 7, 7, 7);
        send(6'b100000); send(6'b100000); send(6'b100000);
        idle(6);
        chk("ext_v", 64'(last_v), 64'(26'h0000300));
        chk("ext_a", 64'(last_a), 64'(26'h3FFFD60));

        // Two samples with kernel_valid held high through the output phase.
        set_rom(1, 1, 5, -1, 2, -1);
        send(1); send(2); send(3);
        send(0); send(0); send(1);
        idle(6);
        chk("b2b_v", 64'(last_v), 64'(RW'(5)));
        chk("b2b_a", 64'(last_a), 64'(26'h3FFFFFF));

        // Reset after two kernels discards the partial sample.
        set_rom(1, 1, 1, -1, 2, 0);
        nv0 = n_vp;
        send(2); send(3);
        step(1'b0, '0, 1'b1, f);
        send(1); send(2); send(3);
        idle(6);
        chk("rst_pulses", 64'(n_vp - nv0), 64'(1));
        chk("rst_v", 64'(last_v), 64'(RW'(6)));
        chk("rst_a", 64'(last_a), 64'(RW'(3)));

        // Randomized traffic with gaps, stalls and occasional resets.
        for (int p = 0; p < 4; p++) begin
            step(1'b0, '0, 1'b1, f);
            set_rom(int'($signed(NB'($urandom))), int'($signed(NB'($urandom))),
                    int'($signed(NB'($urandom))), int'($signed(NB'($urandom))),
                    int'($signed(NB'($urandom))), int'($signed(NB'($urandom))));
            for (int i = 0; i < 200; i++)
                step(($urandom_range(0, 3) != 0), KW'($urandom),
                     ($urandom_range(0, 49) == 0), f);
            idle(6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/svm_matmul2.md
# svm_matmul2

Second matrix-multiply stage of the systolic SVM classifier. Consumes the stream of per-support-vector kernel values produced by the first matmul stage, multiplies each against the valence and arousal dual coefficients read from the coefficient ROM, and accumulates both dot products in parallel. When a sample completes, it emits the valence sum and then the arousal sum on one shared result bus, one cycle apart. These are the `matmul2_result`, `matmul2_v_valid` and `matmul2_a_valid` inputs of the decision stage.

## Interface
- NBITS, 16: coefficient width (signed).
- F_WIDTH, 214: feature count; used only through LOG_F_WIDTH.
- LOG_F_WIDTH, 8: growth bits of the matmul1 kernel value. Kernel width is K_W = NBITS+LOG_F_WIDTH.
- SUP_WIDTH, 100: support vectors per sample.
- LOG_SUP_WIDTH, 7: counter/address width and accumulation growth bits. Requires 2^LOG_SUP_WIDTH >= SUP_WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- kernel_data  in  K_W  signed kernel value for the current support vector.
- kernel_valid  in  1  kernel_data valid.
- kernel_ready  out  1  block accepts kernel_data; fire = kernel_valid && kernel_ready.
- alpha_addr  out  LOG_SUP_WIDTH  coefficient ROM address.
- v_alpha  in  NBITS  signed valence coefficient; ROM read latency 1 cycle.
- a_alpha  in  NBITS  signed arousal coefficient; ROM read latency 1 cycle.
- matmul2_result  out  NBITS*(NBITS+LOG_F_WIDTH)+LOG_SUP_WIDTH  signed sum, sign-extended.
- matmul2_v_valid  out  1  result holds the valence sum (1-cycle pulse).
- matmul2_a_valid  out  1  result holds the arousal sum (1-cycle pulse).

## Operation
- States:
  - ACCUM: kernel_ready=1.
  - FLUSH: kernel_ready=0.
  - OUT_V: kernel_ready=0.
  - OUT_A: kernel_ready=0.
- Reset state: ACCUM, idx=0.
- Reset values: accumulators=0, matmul2_result=0, both valids=0, stage-1 valid=0.
- ACCUM behaviour:
  - alpha_addr = idx combinationally.
  - On fire: register kernel_data into k_reg and set stage-1 valid; increment idx.
  - If idx==SUP_WIDTH-1 at fire: idx←0 and state→FLUSH.
  - No fire: idx and state hold, and stage-1 valid clears.
- Stage 1 (cycle after a fire): v_acc += k_reg*v_alpha and a_acc += k_reg*a_alpha.
  - Products are full precision: NBITS+K_W bits, signed×signed.
  - Accumulators are NBITS+K_W+LOG_SUP_WIDTH bits; overflow is impossible by construction, so no saturation logic.
- FLUSH: lets the last product land; unconditionally → OUT_V.
- OUT_V:
  - Register matmul2_result←sext(v_acc) and matmul2_v_valid←1.
  - → OUT_A.
- OUT_A:
  - Register matmul2_result←sext(a_acc), matmul2_a_valid←1, matmul2_v_valid←0.
  - Clear both accumulators; → ACCUM.
- Next edge after OUT_A: matmul2_a_valid←0.
- matmul2_result holds its last value otherwise; it is don't-care while both valids are 0.
- No downstream backpressure: the decision stage always accepts. Upstream is throttled only by kernel_ready.
- kernel_data is ignored whenever kernel_ready=0.

## Timing
- Last kernel fires at edge t:
  - edge t+1: final accumulate.
  - edge t+2: v_valid=1 with the valence sum, for the cycle t+2..t+3.
  - edge t+3: a_valid=1 with the arousal sum, v_valid=0.
  - edge t+4: a_valid=0.
- kernel_ready falls the cycle after the last fire (edge t) and returns high at edge t+3.
- The first kernel of the next sample may fire at edge t+4. Stage 1 of that kernel adds into the accumulators cleared at edge t+3.
- Minimum period per sample: SUP_WIDTH+3 cycles.
- v_valid and a_valid are never high in the same cycle.
- Gaps (kernel_valid=0) mid-sample: index and accumulators hold; result unaffected.
- rst mid-sample or mid-output: next cycle is ACCUM with idx=0, accumulators cleared, valids 0. The partial sample is discarded and no pulse is emitted.
- alpha_addr must equal the index of the kernel being fired in that cycle. ROM data then aligns with k_reg in stage 1.

## Test plan
- Setup: NBITS=4, LOG_F_WIDTH=2, SUP_WIDTH=3, LOG_SUP_WIDTH=2.
- Kernels 1,2,3 back-to-back; v_alpha 1,1,1; a_alpha −1,2,0 → v_valid with result 6 at t+2; a_valid with result 3 at t+3; kernel_ready low t..t+2.
- Same stimulus with kernel_valid dropped for 2 cycles between kernels 1 and 2 → identical results; pulses shifted by exactly 2 cycles.
- Extremes: kernels −32,−32,−32, v_alpha −8 each, a_alpha 7 each → v=768, a=−672, correct sign extension on the full bus.
- Two samples back-to-back with kernel_valid held high: second sample kernels 0,0,1 with alpha v=5, a=−1 at index 2 → second pair 5, −1. No carry-over from the first sample; first fire of the second sample at t+4.
- rst asserted for 1 cycle after the 2nd kernel, then a fresh 3-kernel sample → only one v/a pulse pair, with values of the fresh sample only.
- Tie kernel_valid high during FLUSH/OUT states → no extra fires; idx and accumulators unchanged.
